// File: rtl/fetch_unit_if.sv
// Fetch stage bus: PC handshake, instruction-memory request/response
// channels and the instruction hand-off toward decode.
interface fetch_if #(
    parameter int XLEN_PC = 32
);
    logic [XLEN_PC-1:0] pc;
    logic               pc_en;
    logic               flush;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN_PC-1:0] imem_req_addr;
    logic               imem_resp_valid;
    logic [31:0]        imem_resp_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [31:0]        inst;
    logic [XLEN_PC-1:0] inst_pc;
    logic               inst_fault;

    modport master (
        input  pc, flush, imem_req_ready, imem_resp_valid,
        input  imem_resp_data, inst_ready,
        output pc_en, imem_req_valid, imem_req_addr,
        output inst_valid, inst, inst_pc, inst_fault
    );

    modport slave (
        output pc, flush, imem_req_ready, imem_resp_valid,
        output imem_resp_data, inst_ready,
        input  pc_en, imem_req_valid, imem_req_addr,
        input  inst_valid, inst, inst_pc, inst_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order
// response tagging, flush drop counting and misaligned-PC fault marker.
module fetch_unit #(
    parameter int DEPTH   = 2,
    parameter int XLEN_PC = 32
) (
    input logic    clk,
    input logic    rst,
    fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {RUN, FAULT_PEND, FAULT_HALT} state_t;

    typedef struct packed {
        logic [XLEN_PC-1:0] pc;
        logic [31:0]        data;
        logic               fault;
    } ent_t;

    state_t             state;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      drop_cnt;
    logic [CW-1:0]      buf_count;
    logic [XLEN_PC-1:0] tags [DEPTH];
    ent_t               obuf [DEPTH];

    logic          credit;
    logic          req_valid;
    logic          acc;
    logic          resp;
    logic          dropping;
    logic          fault_push;
    logic          pop;
    logic          push;
    ent_t          push_ent;
    logic [CW-1:0] obuf_wr;
    logic [CW-1:0] tag_wr;

    assign credit = ({1'b0, outstanding} + {1'b0, buf_count}) < DEPTH_W;
    assign req_valid = rst & (state == RUN) & ~bus.flush
                     & (bus.pc[1:0] == 2'b00) & credit;
    assign acc = req_valid & bus.imem_req_ready;
    assign resp = bus.imem_resp_valid;
    assign dropping = drop_cnt != '0;
    assign fault_push = (state == FAULT_PEND) & ~bus.flush
                      & (outstanding == '0) & ({1'b0, buf_count} < DEPTH_W);
    assign pop = (buf_count != '0) & bus.inst_ready;
    assign push = ~bus.flush & ((resp & ~dropping) | fault_push);
    assign obuf_wr = buf_count - CW'(pop);
    assign tag_wr = outstanding - CW'(resp);

    assign bus.pc_en          = acc;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = bus.pc;
    assign bus.inst_valid     = buf_count != '0;
    assign bus.inst           = obuf[0].data;
    assign bus.inst_pc        = obuf[0].pc;
    assign bus.inst_fault     = obuf[0].fault;

    // Entry entering the output buffer: fault marker or tagged response.
    always_comb begin
        push_ent = '0;
        if (fault_push) begin
            push_ent.pc    = bus.pc;
            push_ent.fault = 1'b1;
        end else begin
            push_ent.pc   = tags[0];
            push_ent.data = bus.imem_resp_data;
        end
    end

    // Control state, in-flight and drop counters, buffer occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            outstanding <= '0;
            drop_cnt    <= '0;
            buf_count   <= '0;
        end else begin
            outstanding <= outstanding + CW'(acc) - CW'(resp);
            if (bus.flush) begin
                drop_cnt  <= outstanding - CW'(resp);
                buf_count <= '0;
                state     <= RUN;
            end else begin
                if (resp & dropping)
                    drop_cnt <= drop_cnt - CW'(1);
                buf_count <= buf_count + CW'(push) - CW'(pop);
                unique case (state)
                    RUN:        if (bus.pc[1:0] != 2'b00) state <= FAULT_PEND;
                    FAULT_PEND: if (fault_push) state <= FAULT_HALT;
                    default:    state <= FAULT_HALT;
                endcase
            end
        end
    end

    // Tag FIFO as a shift queue: head at index 0, kept across flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
        end else begin
            if (resp)
                for (int i = 0; i < DEPTH - 1; i++) tags[i] <= tags[i + 1];
            if (acc)
                for (int i = 0; i < DEPTH; i++)
                    if (CW'(i) == tag_wr) tags[i] <= bus.pc;
        end
    end

    // Output buffer as a shift queue: head drives inst_* directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) obuf[i] <= '0;
        end else if (!bus.flush) begin
            if (pop)
                for (int i = 0; i < DEPTH - 1; i++) obuf[i] <= obuf[i + 1];
            if (push)
                for (int i = 0; i < DEPTH; i++)
                    if (CW'(i) == obuf_wr) obuf[i] <= push_ent;
        end
    end

    // A response with nothing in flight means the memory broke ordering.
    resp_underflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(bus.imem_resp_valid && outstanding == '0)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;
    localparam int DEPTH = 2;
    localparam int LAT   = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.XLEN_PC(32)) bus ();

    fetch_unit #(.DEPTH(DEPTH), .XLEN_PC(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        f;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ent_t        m_out [$];
    logic [31:0] m_tags [$];
    int          m_drop;
    int          m_st;
    mreq_t       memq [$];
    ent_t        log_q [$];
    int          cyc;
    bit          acc_seen;
    bit          mem_hold;
    int          n_run;
    int          n_fail;
    int          n_out0;
    int          n_tag0;
    logic        exp_rv;
    logic [31:0] t;
    logic [31:0] p3;
    logic [31:0] p6;
    int          nacc;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 3) ^ 32'h1357_9BDF;
    endfunction

    function automatic ent_t log_at(int i);
        ent_t e;
        e = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: compare at negedge, then advance to next edge.
    always @(negedge clk) begin
        if (!rst) begin
            m_out.delete();
            m_tags.delete();
            m_drop = 0;
            m_st = 0;
        end else begin
            n_out0 = m_out.size();
            n_tag0 = m_tags.size();
            exp_rv = (m_st == 0) && !bus.flush && (bus.pc[1:0] == 2'b00)
                     && (n_tag0 + n_out0 < DEPTH);
            chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
            if (exp_rv) chk("req_addr", bus.imem_req_addr, bus.pc);
            chk("pc_en", 32'(bus.pc_en), 32'(exp_rv & bus.imem_req_ready));
            chk("inst_valid", 32'(bus.inst_valid), 32'(n_out0 != 0));
            if (n_out0 != 0) begin
                chk("inst_pc", bus.inst_pc, m_out[0].pc);
                chk("inst", bus.inst, m_out[0].data);
                chk("inst_fault", 32'(bus.inst_fault), 32'(m_out[0].f));
            end
            if (bus.inst_valid && bus.inst_ready)
                log_q.push_back('{bus.inst_pc, bus.inst, bus.inst_fault});
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                memq.push_back('{bus.imem_req_addr, cyc + LAT});
                acc_seen = 1'b1;
            end
            t = 32'hDEAD_BEEF;
            if (bus.imem_resp_valid && m_tags.size() != 0)
                t = m_tags.pop_front();
            if (bus.flush) begin
                m_out.delete();
                m_drop = m_tags.size();
                m_st = 0;
            end else begin
                if (n_out0 != 0 && bus.inst_ready) void'(m_out.pop_front());
                if (bus.imem_resp_valid) begin
                    if (m_drop > 0) m_drop--;
                    else m_out.push_back('{t, bus.imem_resp_data, 1'b0});
                end
                if (exp_rv && bus.imem_req_ready) m_tags.push_back(bus.pc);
                if (m_st == 0 && bus.pc[1:0] != 2'b00) begin
                    m_st = 1;
                end else if (m_st == 1 && n_tag0 == 0 && n_out0 < DEPTH) begin
                    m_out.push_back('{bus.pc, 32'h0, 1'b1});
                    m_st = 2;
                end
            end
        end
    end

    // Program counter and in-order memory with fixed latency.
    always @(posedge clk) begin
        mreq_t m;
        #1;
        cyc++;
        bus.imem_resp_valid = 1'b0;
        if (!rst) begin
            memq.delete();
            acc_seen = 1'b0;
        end else begin
            if (acc_seen) bus.pc = bus.pc + 32'd4;
            acc_seen = 1'b0;
            if (!mem_hold && memq.size() != 0 && memq[0].due <= cyc) begin
                m = memq.pop_front();
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data = mem_word(m.addr);
            end
        end
    end

    initial begin
        n_run = 0;
        n_fail = 0;
        cyc = 0;
        mem_hold = 1'b0;
        bus.pc = 32'h0;
        bus.flush = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = 32'h0;
        bus.inst_ready = 1'b1;

        // Reset state
        step(3);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_pc_en", 32'(bus.pc_en), 0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_inst_pc", bus.inst_pc, 0);
        chk("rst_inst_fault", 32'(bus.inst_fault), 0);
        rst = 1'b1;

        // Streaming from pc 0
        log_q.delete();
        step(12);
        chk("t2_pc0", log_at(0).pc, 32'h0);
        chk("t2_pc1", log_at(1).pc, 32'h4);
        chk("t2_pc2", log_at(2).pc, 32'h8);
        chk("t2_data0", log_at(0).data, mem_word(32'h0));
        chk("t2_data2", log_at(2).data, mem_word(32'h8));

        // Asynchronous reset mid-fetch
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t1_req_valid", 32'(bus.imem_req_valid), 0);
        chk("t1_pc_en", 32'(bus.pc_en), 0);
        chk("t1_inst_valid", 32'(bus.inst_valid), 0);
        chk("t1_inst", bus.inst, 0);
        chk("t1_inst_pc", bus.inst_pc, 0);
        chk("t1_inst_fault", 32'(bus.inst_fault), 0);
        bus.pc = 32'h40;
        step(2);
        rst = 1'b1;
        log_q.delete();
        @(negedge clk);
        #1;
        chk("t1_first_req", 32'(bus.imem_req_valid), 1);
        chk("t1_first_addr", bus.imem_req_addr, 32'h40);
        step(6);
        chk("t1_first_inst_pc", log_at(0).pc, 32'h40);

        // Memory not ready for 5 cycles
        bus.imem_req_ready = 1'b0;
        step(4);
        p6 = bus.pc;
        repeat (5) begin
            @(negedge clk);
            chk("t6_req_valid", 32'(bus.imem_req_valid), 1);
            chk("t6_addr", bus.imem_req_addr, p6);
            chk("t6_pc_en", 32'(bus.pc_en), 0);
            @(posedge clk);
            #2;
        end

        // Back-pressure from decode
        p3 = bus.pc;
        bus.inst_ready = 1'b0;
        bus.imem_req_ready = 1'b1;
        nacc = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) nacc++;
            @(posedge clk);
            #2;
        end
        chk("t3_accepts", 32'(nacc), 2);
        chk("t3_req_valid", 32'(bus.imem_req_valid), 0);
        chk("t3_inst_valid", 32'(bus.inst_valid), 1);
        log_q.delete();
        bus.inst_ready = 1'b1;
        step(8);
        chk("t3_pc0", log_at(0).pc, p3);
        chk("t3_pc1", log_at(1).pc, p3 + 32'd4);
        chk("t3_pc2", log_at(2).pc, p3 + 32'd8);

        // Flush with two requests in flight
        mem_hold = 1'b1;
        step(5);
        bus.flush = 1'b1;
        bus.pc = 32'h100;
        mem_hold = 1'b0;
        log_q.delete();
        step(1);
        bus.flush = 1'b0;
        step(8);
        chk("t4_pc0", log_at(0).pc, 32'h100);
        chk("t4_pc1", log_at(1).pc, 32'h104);
        chk("t4_data0", log_at(0).data, mem_word(32'h100));

        // Misaligned PC with one request in flight
        bus.imem_req_ready = 1'b0;
        step(4);
        bus.flush = 1'b1;
        bus.pc = 32'h200;
        mem_hold = 1'b1;
        bus.imem_req_ready = 1'b1;
        log_q.delete();
        step(1);
        bus.flush = 1'b0;
        step(1);
        bus.pc = 32'h102;
        step(2);
        mem_hold = 1'b0;
        step(6);
        chk("t5_count", 32'(log_q.size()), 2);
        chk("t5_pc0", log_at(0).pc, 32'h200);
        chk("t5_fault0", 32'(log_at(0).f), 0);
        chk("t5_pc1", log_at(1).pc, 32'h102);
        chk("t5_fault1", 32'(log_at(1).f), 1);
        chk("t5_inst1", log_at(1).data, 32'h0);
        nacc = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.imem_req_valid) nacc++;
            @(posedge clk);
            #2;
        end
        chk("t5_halted", 32'(nacc), 0);
        bus.flush = 1'b1;
        bus.pc = 32'h300;
        step(1);
        bus.flush = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_resume_valid", 32'(bus.imem_req_valid), 1);
        chk("t5_resume_addr", bus.imem_req_addr, 32'h300);
        step(6);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
